// File: rtl/gen3_scrambler_ctrl.sv
// Per-lane Gen3 (128b/130b) scrambler sequencer: frames 16-byte blocks, classifies them,
// steers LFSR seed-load/advance and XORs the LFSR byte onto payload that must be scrambled.
module gen3_scrambler_ctrl #(
  parameter logic [22:0] SEED      = 23'h1DBFBC,
  parameter int unsigned BLK_BYTES = 16
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_blk_start,
  input  logic [1:0] in_sync_hdr,
  input  logic [7:0] in_data,
  input  logic       scr_disable,
  input  logic [7:0] lfsr_byte,
  output logic       scr_seed_load,
  output logic       scr_adv,
  output logic       out_valid,
  output logic       out_blk_start,
  output logic [1:0] out_sync_hdr,
  output logic [7:0] out_data,
  output logic       err_pulse
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_BYTES - 1);
  localparam logic [1:0] HDR_DATA  = 2'b01;
  localparam logic [1:0] HDR_OS    = 2'b10;

  // The seed lives in the external LFSR; an all-zero seed would lock it up.
  if (SEED == 23'd0 || BLK_BYTES != 16) begin : g_param_chk
    $error("gen3_scrambler_ctrl: SEED must be non-zero and BLK_BYTES must be 16");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_TS, S_OSBYP, S_SKP, S_EIEOS, S_BADHDR
  } state_e;

  state_e           state_q, state_d, cls_c, cur_state_c;
  logic [CNT_W-1:0] cnt_q, cnt_d, cur_cnt_c;
  logic             post_rst_q;
  logic             out_valid_q, out_blk_start_q, err_q;
  logic [1:0]       out_sync_hdr_q;
  logic [7:0]       out_data_q;
  logic             blk_c, hdr_bad_c, xor_en_c, adv_c, eieos_load_c, err_d;

  assign blk_c = in_valid & in_blk_start;

  // Block type from the sync header and the first payload byte.
  always_comb begin
    cls_c     = S_OSBYP;
    hdr_bad_c = 1'b0;
    case (in_sync_hdr)
      HDR_DATA: cls_c = S_DATA;
      HDR_OS: begin
        case (in_data)
          8'h00:        cls_c = S_EIEOS;
          8'hAA:        cls_c = S_SKP;
          8'h1E, 8'h2D: cls_c = S_TS;
          default:      cls_c = S_OSBYP;
        endcase
      end
      default: begin
        cls_c     = S_BADHDR;
        hdr_bad_c = 1'b1;
      end
    endcase
  end

  // A block start always restarts framing at byte 0, abandoning any open block.
  assign cur_state_c = blk_c ? cls_c : state_q;
  assign cur_cnt_c   = blk_c ? '0 : cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    xor_en_c     = 1'b0;
    adv_c        = 1'b0;
    eieos_load_c = 1'b0;
    err_d        = 1'b0;
    if (in_valid) begin
      err_d = blk_c & (hdr_bad_c | (cnt_q != '0));
      if (cur_state_c == S_IDLE) begin
        err_d = 1'b1;
      end else begin
        case (cur_state_c)
          S_DATA: begin
            xor_en_c = 1'b1;
            adv_c    = 1'b1;
          end
          S_TS: begin
            xor_en_c = (cur_cnt_c != '0);
            adv_c    = 1'b1;
          end
          S_OSBYP: adv_c = 1'b1;
          S_EIEOS: begin
            adv_c        = (cur_cnt_c != CNT_LAST);
            eieos_load_c = (cur_cnt_c == CNT_LAST);
          end
          default: ;
        endcase
        cnt_d   = cur_cnt_c + CNT_W'(1);
        state_d = (cur_cnt_c == CNT_LAST) ? S_IDLE : cur_state_c;
      end
    end
  end

  // Seed load has priority over advance so the LFSR never does both on one edge.
  assign scr_seed_load = reset | post_rst_q | eieos_load_c;
  assign scr_adv       = adv_c & ~scr_seed_load;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      post_rst_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      out_blk_start_q <= 1'b0;
      out_sync_hdr_q  <= 2'b00;
      out_data_q      <= 8'h00;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      post_rst_q      <= 1'b0;
      out_valid_q     <= in_valid;
      out_blk_start_q <= blk_c;
      err_q           <= err_d;
      if (blk_c) out_sync_hdr_q <= in_sync_hdr;
      if (in_valid) out_data_q <= in_data ^ ((xor_en_c & ~scr_disable) ? lfsr_byte : 8'h00);
    end
  end

  assign out_valid     = out_valid_q;
  assign out_blk_start = out_blk_start_q;
  assign out_sync_hdr  = out_sync_hdr_q;
  assign out_data      = out_data_q;
  assign err_pulse     = err_q;

endmodule

// File: tb/tb_gen3_scrambler_ctrl.sv
// Randomized scoreboard bench for gen3_scrambler_ctrl with a behavioural LFSR and a
// block-level reference model tracking the position in the LFSR byte stream.
module tb_gen3_scrambler_ctrl;

  localparam logic [22:0] SEED = 23'h1DBFBC;
  localparam int unsigned SEQ_N = 4096;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_blk_start = 1'b0, scr_disable = 1'b0;
  logic [1:0] in_sync_hdr = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic [7:0] lfsr_byte;
  logic       scr_seed_load, scr_adv, out_valid, out_blk_start, err_pulse;
  logic [1:0] out_sync_hdr;
  logic [7:0] out_data;

  gen3_scrambler_ctrl #(.SEED(SEED), .BLK_BYTES(16)) dut (
    .pclk(pclk), .reset(reset), .in_valid(in_valid), .in_blk_start(in_blk_start),
    .in_sync_hdr(in_sync_hdr), .in_data(in_data), .scr_disable(scr_disable),
    .lfsr_byte(lfsr_byte), .scr_seed_load(scr_seed_load), .scr_adv(scr_adv),
    .out_valid(out_valid), .out_blk_start(out_blk_start), .out_sync_hdr(out_sync_hdr),
    .out_data(out_data), .err_pulse(err_pulse)
  );

  always #5 pclk = ~pclk;

  // Gen3 polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, eight bit-steps per byte.
  function automatic logic [22:0] step8(input logic [22:0] s);
    logic [22:0] t = s;
    for (int i = 0; i < 8; i++) t = {t[21:0], t[22] ^ t[20] ^ t[15] ^ t[7] ^ t[4] ^ t[1]};
    return t;
  endfunction

  function automatic logic [7:0] peek8(input logic [22:0] s);
    logic [22:0] t = s;
    logic [7:0]  b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = t[22];
      t = {t[21:0], t[22] ^ t[20] ^ t[15] ^ t[7] ^ t[4] ^ t[1]};
    end
    return b;
  endfunction

  logic [22:0] lf = SEED;
  always @(posedge pclk) begin
    if (scr_seed_load) lf <= SEED;
    else if (scr_adv)  lf <= step8(lf);
  end
  assign lfsr_byte = peek8(lf);

  typedef struct packed {
    logic [7:0] d;
    logic       bs;
    logic [1:0] h;
    logic       err;
    logic       adv;
    logic       ld;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] seq [SEQ_N];
  logic [7:0] last_d = 8'h00;
  int         m_pos = 0;
  bit         m_open = 1'b0;
  logic [1:0] m_hdr = 2'b00;
  int         n_chk = 0, n_pass = 0;
  logic       adv_seen = 1'b0, ld_seen = 1'b0, rst_seen = 1'b1, stall_seen = 1'b0;
  logic       stall_win = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Combinational strobes are captured at the edge they act on.
  always @(posedge pclk) begin
    adv_seen   <= scr_adv;
    ld_seen    <= scr_seed_load;
    rst_seen   <= reset;
    stall_seen <= stall_win & ~in_valid;
  end

  always @(negedge pclk) begin
    if (!rst_seen) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data",      32'(out_data),      32'(mon_e.d));
          chk("out_blk_start", 32'(out_blk_start), 32'(mon_e.bs));
          chk("out_sync_hdr",  32'(out_sync_hdr),  32'(mon_e.h));
          chk("err_pulse",     32'(err_pulse),     32'(mon_e.err));
          chk("scr_adv",       32'(adv_seen),      32'(mon_e.adv));
          chk("scr_seed_load", 32'(ld_seen),       32'(mon_e.ld));
          last_d = mon_e.d;
        end
      end else if (stall_seen) begin
        chk("stall_adv",  32'(adv_seen), 32'd0);
        chk("stall_hold", 32'(out_data), 32'(last_d));
      end
    end
  end

  task automatic drive(input logic v, input logic bs, input logic [1:0] h, input logic [7:0] d,
                       input logic dis, input logic stall);
    @(negedge pclk);
    in_valid     = v;
    in_blk_start = bs;
    in_sync_hdr  = h;
    in_data      = d;
    scr_disable  = dis;
    stall_win    = stall;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
  endtask

  // Reference model: expected output of each byte from the block-type rules.
  task automatic send_block(input logic [1:0] h, input logic [7:0] b[16], input int n,
                            input int stall_at, input int stall_len, input bit dis);
    bit   is_data = (h == 2'b01);
    bit   is_os   = (h == 2'b10);
    bit   bad     = !is_data && !is_os;
    bit   eie     = is_os && (b[0] == 8'h00);
    bit   skp     = is_os && (b[0] == 8'hAA);
    bit   ts      = is_os && (b[0] == 8'h1E || b[0] == 8'h2D);
    bit   early   = m_open;
    exp_t e;
    m_hdr = h;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at)
        for (int s = 0; s < stall_len; s++) drive(1'b0, 1'b0, h, 8'h5C, dis, 1'b1);
      e.ld  = eie && (i == 15);
      e.adv = !e.ld && (is_data || (is_os && !skp));
      e.d   = b[i] ^ ((!dis && (is_data || (ts && i > 0))) ? seq[m_pos] : 8'h00);
      e.bs  = (i == 0);
      e.h   = h;
      e.err = (i == 0) && (bad || early);
      drive(1'b1, i == 0, h, b[i], dis, 1'b0);
      sb.push_back(e);
      if (e.ld) m_pos = 0;
      else if (e.adv) m_pos++;
    end
    m_open = (n < 16);
  endtask

  task automatic send_stray(input logic [7:0] d);
    exp_t e;
    e.d = d; e.bs = 1'b0; e.h = m_hdr; e.err = 1'b1; e.adv = 1'b0; e.ld = 1'b0;
    drive(1'b1, 1'b0, 2'(($urandom)), d, 1'b0, 1'b0);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    idle(3);
    @(negedge pclk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_outputs", 32'({out_valid, out_blk_start, out_sync_hdr, out_data, err_pulse, scr_adv}), 32'd0);
    chk("rst_seed_load", 32'(scr_seed_load), 32'd1);
    reset = 1'b0;
    #1 chk("post_rst_seed_load", 32'(scr_seed_load), 32'd1);
    @(negedge pclk);
    #1 chk("seed_load_released", 32'({scr_seed_load, scr_adv}), 32'd0);
    m_pos = 0; m_open = 1'b0; m_hdr = 2'b00;
  endtask

  logic [7:0] z[16], eie_b[16], skp_b[16], ts_b[16], rb[16];
  int         kind, n, sat, slen;
  bit         dis;
  logic [1:0] hdr;

  initial begin
    logic [22:0] s = SEED;
    for (int k = 0; k < SEQ_N; k++) begin
      seq[k] = peek8(s);
      s = step8(s);
    end
    for (int i = 0; i < 16; i++) begin
      z[i]     = 8'h00;
      eie_b[i] = (i % 2 == 0) ? 8'h00 : 8'hFF;
      skp_b[i] = 8'hAA;
      ts_b[i]  = (i == 0) ? 8'h1E : 8'h4A;
    end
    skp_b[15] = 8'hE1;

    do_reset();
    send_block(2'b01, z, 16, -1, 0, 1'b0);
    send_block(2'b10, eie_b, 16, -1, 0, 1'b0);
    send_block(2'b01, z, 16, -1, 0, 1'b0);
    send_block(2'b10, skp_b, 16, -1, 0, 1'b0);
    send_block(2'b01, z, 16, -1, 0, 1'b0);
    send_block(2'b10, ts_b, 16, -1, 0, 1'b0);
    send_block(2'b11, z, 16, -1, 0, 1'b0);
    send_block(2'b01, z, 7, -1, 0, 1'b0);
    send_block(2'b01, z, 16, -1, 0, 1'b0);
    send_block(2'b01, z, 16, 5, 3, 1'b0);
    send_stray(8'h3C);
    send_block(2'b10, eie_b, 9, -1, 0, 1'b0);
    send_block(2'b01, z, 16, -1, 0, 1'b0);
    send_block(2'b01, z, 5, -1, 0, 1'b0);
    do_reset();
    send_block(2'b01, z, 16, -1, 0, 1'b1);
    send_block(2'b01, z, 16, -1, 0, 1'b0);

    for (int blk = 0; blk < 60; blk++) begin
      if (!m_open && $urandom_range(9) == 0) send_stray(8'($urandom));
      for (int i = 0; i < 16; i++) rb[i] = 8'($urandom);
      kind = int'($urandom_range(6));
      hdr  = (kind == 0) ? 2'b01 : 2'b10;
      case (kind)
        1: rb[0] = 8'h00;
        2: rb[0] = 8'hAA;
        3: rb[0] = 8'h1E;
        4: rb[0] = 8'h2D;
        5: while (rb[0] == 8'h00 || rb[0] == 8'hAA || rb[0] == 8'h1E || rb[0] == 8'h2D)
             rb[0] = 8'($urandom);
        6: hdr = ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
        default: ;
      endcase
      n    = ($urandom_range(5) == 0) ? int'($urandom_range(15, 1)) : 16;
      sat  = ($urandom_range(3) == 0) ? int'($urandom_range(15, 1)) : -1;
      slen = int'($urandom_range(3, 1));
      dis  = ($urandom_range(4) == 0);
      send_block(hdr, rb, n, sat, slen, dis);
      idle(int'($urandom_range(2)));
    end

    idle(2);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge pclk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
